// File: rtl/instr_encoder.sv
// MIPS instruction encoder: turns ALUOp requests into 32-bit words and queues them
// in a 2-entry FIFO with valid/ready handshakes on both sides and a saturating word counter.
module instr_encoder #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic             in_imm,
    input  logic [4:0]       in_rs,
    input  logic [4:0]       in_rt,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_shamt,
    input  logic [15:0]      in_immval,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             err,
    output logic [CNT_W-1:0] count
);

    logic [31:0]      ent0_q, ent1_q;
    logic [1:0]       occ_q;
    logic             err_q;
    logic [CNT_W-1:0] count_q;

    logic        legal;
    logic [5:0]  op_f;
    logic [5:0]  func_f;
    logic [4:0]  rs_f;
    logic [4:0]  sh_f;
    logic [31:0] word;
    logic        accept;
    logic        push;
    logic        pop;

    always_comb begin
        legal  = 1'b1;
        op_f   = 6'b000000;
        func_f = 6'b000000;
        rs_f   = in_rs;
        sh_f   = 5'd0;
        if (in_imm) begin
            case (in_op)
                4'b0000: op_f = 6'b001000;
                4'b0100: op_f = 6'b001101;
                default: legal = 1'b0;
            endcase
        end else begin
            case (in_op)
                4'b0000: func_f = 6'b100000;
                4'b0001: func_f = 6'b100010;
                4'b0011: func_f = 6'b100100;
                4'b0100: func_f = 6'b100101;
                4'b0101: func_f = 6'b101010;
                // Shifts take the amount from shamt and leave rs zero.
                4'b1000: begin
                    func_f = 6'b000000;
                    rs_f   = 5'd0;
                    sh_f   = in_shamt;
                end
                4'b1001: begin
                    func_f = 6'b000010;
                    rs_f   = 5'd0;
                    sh_f   = in_shamt;
                end
                4'b0010: begin
                    op_f   = 6'b011100;
                    func_f = 6'b000010;
                end
                4'b1010: begin
                    op_f   = 6'b011100;
                    func_f = 6'b000110;
                end
                4'b1011: begin
                    op_f   = 6'b011100;
                    func_f = 6'b100001;
                end
                4'b1100: begin
                    op_f   = 6'b011100;
                    func_f = 6'b100000;
                end
                default: legal = 1'b0;
            endcase
        end
        word = in_imm ? {op_f, in_rs, in_rt, in_immval}
                      : {op_f, rs_f, in_rt, in_rd, sh_f, func_f};
    end

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign in_ready  = !rst && ((occ_q != 2'd2) || out_ready);
    assign out_valid = (occ_q != 2'd0);
    assign out_instr = ent0_q;
    assign err       = err_q;
    assign count     = count_q;

    assign accept = in_valid && in_ready;
    assign push   = accept && legal;
    assign pop    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            ent0_q  <= 32'd0;
            ent1_q  <= 32'd0;
            occ_q   <= 2'd0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            err_q <= accept && !legal;
            if (pop && (count_q != '1)) begin
                count_q <= count_q + CNT_W'(1);
            end
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        ent0_q <= word;
                    end else begin
                        ent1_q <= word;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    ent0_q <= ent1_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        ent0_q <= word;
                    end else begin
                        ent0_q <= ent1_q;
                        ent1_q <= word;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: vector table of hand-encoded words plus handshake corner sequences,
// with a queue scoreboard and a saturating count model (CNT_W reduced to 4).
`timescale 1ns/1ps
module tb_instr_encoder;

    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_op;
    logic          in_imm;
    logic [4:0]    in_rs, in_rt, in_rd, in_shamt;
    logic [15:0]   in_immval;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic          err;
    logic [CW-1:0] count;

    instr_encoder #(.CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_imm    (in_imm),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_shamt  (in_shamt),
        .in_immval (in_immval),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .err       (err),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic        imm;
        logic [4:0]  rs, rt, rd, shamt;
        logic [15:0] immval;
        logic        legal;
        logic [31:0] word;
    } vec_t;

    localparam int NV = 15;
    localparam int NL = 13;  // entries 0..NL-1 are legal
    vec_t vec[NV];

    logic [31:0]   q[$];
    logic [CW-1:0] cnt_model;
    logic          cur_legal;
    logic [31:0]   cur_word;
    logic          last_acc;
    int            checks   = 0;
    int            failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int idx);
        in_op     = vec[idx].op;
        in_imm    = vec[idx].imm;
        in_rs     = vec[idx].rs;
        in_rt     = vec[idx].rt;
        in_rd     = vec[idx].rd;
        in_shamt  = vec[idx].shamt;
        in_immval = vec[idx].immval;
        cur_legal = vec[idx].legal;
        cur_word  = vec[idx].word;
    endtask

    // One clock: sample handshakes at the falling edge, update models, check after the edge.
    task automatic cycle();
        logic        hold;
        logic [31:0] hold_word;
        logic        nxt_err;
        logic [31:0] w;
        @(negedge clk);
        hold      = out_valid && !out_ready && !rst;
        hold_word = out_instr;
        nxt_err   = 1'b0;
        last_acc  = 1'b0;
        chk("in_ready", {31'd0, in_ready},
            {31'd0, (!rst && ((q.size() < 2) || out_ready))});
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_word", out_instr, 32'hxxxxxxxx);
                end else begin
                    w = q.pop_front();
                    chk("out_instr_order", out_instr, w);
                end
                if (cnt_model != '1) cnt_model = cnt_model + 1'b1;
            end
            if (in_valid && in_ready) begin
                last_acc = 1'b1;
                if (cur_legal) q.push_back(cur_word);
                else nxt_err = 1'b1;
            end
        end else begin
            q.delete();
            cnt_model = '0;
        end
        @(posedge clk);
        #1;
        chk("err", {31'd0, err}, {31'd0, nxt_err});
        chk("count", {28'd0, count}, {28'd0, cnt_model});
        chk("out_valid", {31'd0, out_valid}, {31'd0, (q.size() != 0)});
        if (hold) chk("out_instr_stable", out_instr, hold_word);
    endtask

    task automatic send(input int idx);
        set_req(idx);
        in_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            cycle();
            if (last_acc) break;
        end
        if (!last_acc) chk("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        vec[0]  = '{4'b0000, 1'b0,  5'd1,  5'd2,  5'd3,  5'd0, 16'h0000, 1'b1, 32'h00221820}; // ADD
        vec[1]  = '{4'b1000, 1'b0,  5'd7,  5'd5,  5'd4,  5'd2, 16'h0000, 1'b1, 32'h00052080}; // SLL
        vec[2]  = '{4'b0000, 1'b1,  5'd9,  5'd8,  5'd0,  5'd0, 16'hFFFF, 1'b1, 32'h2128FFFF}; // ADDI
        vec[3]  = '{4'b0001, 1'b0,  5'd2,  5'd3,  5'd1,  5'd5, 16'h0000, 1'b1, 32'h00430822}; // SUB
        vec[4]  = '{4'b0010, 1'b0,  5'd4,  5'd5,  5'd6,  5'd0, 16'h0000, 1'b1, 32'h70853002}; // MUL
        vec[5]  = '{4'b1100, 1'b0,  5'd31, 5'd0,  5'd31, 5'd0, 16'h0000, 1'b1, 32'h73E0F820}; // CLZ
        vec[6]  = '{4'b0100, 1'b1,  5'd0,  5'd31, 5'd0,  5'd0, 16'h1234, 1'b1, 32'h341F1234}; // ORI
        vec[7]  = '{4'b1001, 1'b0,  5'd3,  5'd10, 5'd11, 5'd31, 16'h0000, 1'b1, 32'h000A5FC2}; // SRL
        vec[8]  = '{4'b1010, 1'b0,  5'd1,  5'd2,  5'd3,  5'd4, 16'h0000, 1'b1, 32'h70221806}; // ROT
        vec[9]  = '{4'b1011, 1'b0,  5'd0,  5'd0,  5'd0,  5'd0, 16'h0000, 1'b1, 32'h70000021}; // CLO
        vec[10] = '{4'b0011, 1'b0,  5'd1,  5'd1,  5'd1,  5'd0, 16'h0000, 1'b1, 32'h00210824}; // AND
        vec[11] = '{4'b0100, 1'b0,  5'd5,  5'd6,  5'd7,  5'd0, 16'h0000, 1'b1, 32'h00A63825}; // OR
        vec[12] = '{4'b0101, 1'b0,  5'd8,  5'd9,  5'd10, 5'd0, 16'h0000, 1'b1, 32'h0109502A}; // SLT
        vec[13] = '{4'b0110, 1'b0,  5'd1,  5'd1,  5'd1,  5'd0, 16'h0000, 1'b0, 32'h00000000};
        vec[14] = '{4'b0001, 1'b1,  5'd1,  5'd1,  5'd1,  5'd0, 16'h00FF, 1'b0, 32'h00000000};

        cnt_model = '0;
        last_acc  = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_req(0);

        // Reset state
        @(posedge clk);
        #1;
        cycle();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_count", {28'd0, count}, 32'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);

        // Table: each word alone through an empty FIFO, one-cycle latency
        out_ready = 1'b1;
        for (int i = 0; i < NV; i++) begin
            set_req(i);
            in_valid = 1'b1;
            cycle();
            in_valid = 1'b0;
            if (vec[i].legal) begin
                chk("latency_valid", {31'd0, out_valid}, 32'd1);
                chk("latency_word", out_instr, vec[i].word);
            end else begin
                chk("illegal_no_word", {31'd0, out_valid}, 32'd0);
            end
            cycle();
        end

        // Backpressure: two fill the FIFO, third waits until out_ready rises
        out_ready = 1'b0;
        send(3);
        send(4);
        set_req(5);
        in_valid = 1'b1;
        repeat (3) cycle();
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        #1;
        send(5);
        repeat (4) cycle();
        chk("drained", q.size(), 32'd0);

        // Full FIFO with accept and transfer together for 10 cycles
        out_ready = 1'b0;
        send(6);
        send(7);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 10; k++) begin
            set_req(k % NL);
            cycle();
            chk("stream_accept", {31'd0, last_acc}, 32'd1);
            chk("stream_occ", q.size(), 32'd2);
        end
        in_valid = 1'b0;
        repeat (4) cycle();
        chk("saturated", {28'd0, count}, {28'd0, {CW{1'b1}}});

        // Reset mid-stream discards queued words
        out_ready = 1'b0;
        send(8);
        send(9);
        rst = 1'b1;
        cycle();
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_count", {28'd0, count}, 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (5) cycle();
        send(10);
        send(11);
        send(2);
        repeat (4) cycle();
        chk("count_after_rst", {28'd0, count}, 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
